inst_decode: RTL and testbench
==============================

// Module: inst_decode
// PURPOSE
//  ID stage of the 5-stage RV32I pipeline; consumes IF/ID inst/pc from inst_fetch.
//  Holds 32x32 register file, decodes, detects load-use/branch hazards, resolves
//  branches/jumps in ID (drives branch/jmp/stall/flush back to fetch), registers ID/EX.
// PARAMETERS
//  FLUSH_INST  32'h0000_0013  NOP encoding (addi x0,x0,0); ID/EX bubbles decode as this
// PORTS
//  clk             in   1   clock, posedge
//  rst             in   1   reset, asynchronous, active-high
//  inst_i          in   32  IF/ID instruction
//  pc_i            in   32  IF/ID pc
//  wb_we_i/wb_rd_i/wb_data_i    in 1/5/32   WB write port
//  ex_we_i/ex_mem_read_i/ex_rd_i in 1/1/5   instr in EX: writes rd / is load / rd
//  mem_we_i/mem_mem_read_i/mem_rd_i/mem_data_i in 1/1/5/32  instr in MEM, ALU result
//  pc_stall_o, if_stall_o       out 1   freeze fetch pc and IF/ID (comb)
//  if_flush_o      out  1   IF/ID loads NOP next edge (comb)
//  branch_o, pc_branch_o        out 1/32  taken conditional branch + target (comb)
//  jmp_o, pc_jmp_o              out 1/32  JAL/JALR + target (comb)
//  id_pc_o, id_imm_o, id_rs1_data_o, id_rs2_data_o  out 32 each  ID/EX data
//  id_rs1_o, id_rs2_o, id_rd_o  out 5 each  register indices for EX forwarding
//  id_alu_op_o     out  4   {funct7[5],funct3} for OP/OP-IMM; 4'h0 (add) otherwise
//  id_funct3_o     out  3   funct3 passthrough (load/store size)
//  id_alu_src_o, id_mem_read_o, id_mem_write_o, id_reg_write_o, id_illegal_o  out 1 each
// BEHAVIOUR
//  - Reset: all ID/EX outputs 0; all regfile entries 0. Comb outputs follow inputs.
//  - Regfile: write posedge when wb_we_i && wb_rd_i!=0; x0 always reads 0.
//    Read comb; WB bypass: wb_we_i && wb_rd_i==rs && rs!=0 -> wb_data_i.
//  - Branch/JALR operands: MEM forward (mem_we_i && !mem_mem_read_i && mem_rd_i==rs
//    && rs!=0 -> mem_data_i) has priority over WB bypass, then regfile.
//  - Decode: LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP. Any other opcode:
//    id_illegal_o=1 with all other controls 0, rd=0; no redirect.
//  - Imm: I/S/B/U/J formats, sign-extended to 32b; AUIPC/LUI imm = inst[31:12]<<12.
//  - Source use: rs1 for JALR,BRANCH,LOAD,STORE,OP-IMM,OP; rs2 for BRANCH,STORE,OP.
//  - stall = (ex_mem_read_i && ex_rd_i!=0 && ex_rd_i matches used rs)
//         | (BRANCH/JALR && ex_we_i && ex_rd_i!=0 && ex_rd_i==used rs)
//         | (BRANCH/JALR && mem_mem_read_i && mem_rd_i!=0 && mem_rd_i==used rs).
//  - stall: pc_stall_o=if_stall_o=1; branch_o=jmp_o=if_flush_o=0; ID/EX <= bubble
//    (all controls 0, rd 0, data 0). Stall repeats each cycle until condition clears.
//  - Redirect (no stall): JAL: jmp_o=1, pc_jmp_o=pc_i+immJ. JALR: jmp_o=1,
//    pc_jmp_o=(rs1+immI)&~1. BRANCH taken (BEQ/BNE/BLT/BGE signed, BLTU/BGEU):
//    branch_o=1, pc_branch_o=pc_i+immB. Never branch_o&&jmp_o. if_flush_o=branch_o|jmp_o.
//    Penalty: exactly one NOP in IF/ID. Not-taken branch: no flush.
//  - JAL/JALR: id_reg_write_o=1, link value pc_i+4 presented as id_imm_o with id_alu_src_o=1
//    and id_rs1_data_o=0 (EX adds). AUIPC: id_rs1_data_o=pc_i. LUI: id_rs1_data_o=0.
//  - Targets wrap modulo 2^32; misaligned targets not trapped.
//  - inst_i==FLUSH_INST decodes as ordinary OP-IMM to x0: reg_write suppressed (rd=0).
//  - Reset mid-operation clears ID/EX and regfile immediately (async).
// TESTING
//  1 WB x5=0xDEAD_BEEF while ID reads add x6,x5,x0 same cycle -> id_rs1_data_o=0xDEAD_BEEF.
//  2 lw x1 in EX (ex_mem_read_i=1,ex_rd_i=1), ID add x2,x1,x3 -> pc_stall_o=if_stall_o=1
//    one cycle, ID/EX bubble, next cycle add issues with id_rs1_o=1.
//  3 x1=x2=7, ID beq x1,x2,+16 at pc 0x100 -> branch_o=1, pc_branch_o=0x110, if_flush_o=1;
//    bne same -> branch_o=0, if_flush_o=0.
//  4 ID jalr x1,-3(x4), x4=0x2005 -> jmp_o=1, pc_jmp_o=0x2002, id_rd_o=1, id_imm_o=pc+4.
//  5 MEM addi x4 result 0x40 (mem_we_i=1), ID beq x4,x0 -> compare uses 0x40, not taken;
//    same with mem_mem_read_i=1 -> one stall cycle.
//  6 inst_i=0xFFFF_FFFF -> id_illegal_o=1 next edge, all controls 0; assert rst mid-run ->
//    all ID/EX outputs 0 without clock edge, x1..x31 read 0.

Source files
------------

// File: rtl/inst_decode.sv
// RV32I ID stage: register file, decode, hazard detection, in-ID branch/jump resolution
// and the ID/EX pipeline register.
module inst_decode #(
   parameter logic [31:0] FLUSH_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   input  logic        ex_we_i,
   input  logic        ex_mem_read_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        mem_we_i,
   input  logic        mem_mem_read_i,
   input  logic [4:0]  mem_rd_i,
   input  logic [31:0] mem_data_i,
   output logic        pc_stall_o,
   output logic        if_stall_o,
   output logic        if_flush_o,
   output logic        branch_o,
   output logic [31:0] pc_branch_o,
   output logic        jmp_o,
   output logic [31:0] pc_jmp_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_imm_o,
   output logic [31:0] id_rs1_data_o,
   output logic [31:0] id_rs2_data_o,
   output logic [4:0]  id_rs1_o,
   output logic [4:0]  id_rs2_o,
   output logic [4:0]  id_rd_o,
   output logic [3:0]  id_alu_op_o,
   output logic [2:0]  id_funct3_o,
   output logic        id_alu_src_o,
   output logic        id_mem_read_o,
   output logic        id_mem_write_o,
   output logic        id_reg_write_o,
   output logic        id_illegal_o
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   logic [31:0] rf [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, link;

   assign opcode = inst_i[6:0];
   assign rd     = (inst_i == FLUSH_INST) ? 5'd0 : inst_i[11:7];
   assign funct3 = inst_i[14:12];
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign link  = pc_i + 32'd4;

   // Register reads with same-cycle WB bypass.
   logic [31:0] rf_rs1, rf_rs2;
   assign rf_rs1 = (rs1 == 5'd0) ? 32'h0 :
                   (wb_we_i && wb_rd_i == rs1) ? wb_data_i : rf[rs1];
   assign rf_rs2 = (rs2 == 5'd0) ? 32'h0 :
                   (wb_we_i && wb_rd_i == rs2) ? wb_data_i : rf[rs2];

   // Branch/JALR operands additionally see ALU results sitting in MEM.
   logic [31:0] br_rs1, br_rs2;
   assign br_rs1 = (rs1 != 5'd0 && mem_we_i && !mem_mem_read_i && mem_rd_i == rs1) ?
                   mem_data_i : rf_rs1;
   assign br_rs2 = (rs2 != 5'd0 && mem_we_i && !mem_mem_read_i && mem_rd_i == rs2) ?
                   mem_data_i : rf_rs2;

   logic        legal, use_rs1, use_rs2, writes_rd, alu_src;
   logic        is_jal, is_jalr, is_branch, is_load, is_store, is_alu;
   logic [31:0] imm, op_a;

   always_comb begin
      legal     = 1'b1;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      alu_src   = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_alu    = 1'b0;
      imm       = 32'h0;
      op_a      = 32'h0;
      case (opcode)
         OpLui: begin
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_u;
         end
         OpAuipc: begin
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_u;
            op_a      = pc_i;
         end
         OpJal: begin
            is_jal    = 1'b1;
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = link;
         end
         OpJalr: begin
            is_jalr   = 1'b1;
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = link;
         end
         OpBranch: begin
            is_branch = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            imm       = imm_b;
            op_a      = rf_rs1;
         end
         OpLoad: begin
            is_load   = 1'b1;
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_i;
            op_a      = rf_rs1;
         end
         OpStore: begin
            is_store  = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_s;
            op_a      = rf_rs1;
         end
         OpImm: begin
            is_alu    = 1'b1;
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm       = imm_i;
            op_a      = rf_rs1;
         end
         OpReg: begin
            is_alu    = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            writes_rd = 1'b1;
            op_a      = rf_rs1;
         end
         default: legal = 1'b0;
      endcase
   end

   logic ex_hit, mem_hit, stall, resolves_in_id;
   assign ex_hit  = ex_rd_i != 5'd0 &&
                    ((use_rs1 && ex_rd_i == rs1) || (use_rs2 && ex_rd_i == rs2));
   assign mem_hit = mem_rd_i != 5'd0 &&
                    ((use_rs1 && mem_rd_i == rs1) || (use_rs2 && mem_rd_i == rs2));
   assign resolves_in_id = is_branch || is_jalr;
   assign stall = (ex_mem_read_i && ex_hit) ||
                  (resolves_in_id && ex_we_i && ex_hit) ||
                  (resolves_in_id && mem_mem_read_i && mem_hit);

   logic taken;
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = br_rs1 == br_rs2;
         3'b001:  taken = br_rs1 != br_rs2;
         3'b100:  taken = $signed(br_rs1) <  $signed(br_rs2);
         3'b101:  taken = $signed(br_rs1) >= $signed(br_rs2);
         3'b110:  taken = br_rs1 <  br_rs2;
         3'b111:  taken = br_rs1 >= br_rs2;
         default: taken = 1'b0;
      endcase
   end

   assign pc_stall_o  = stall;
   assign if_stall_o  = stall;
   assign branch_o    = !stall && is_branch && taken;
   assign jmp_o       = !stall && (is_jal || is_jalr);
   assign if_flush_o  = branch_o || jmp_o;
   assign pc_branch_o = pc_i + imm_b;
   assign pc_jmp_o    = is_jal ? pc_i + imm_j : (br_rs1 + imm_i) & ~32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else if (wb_we_i && wb_rd_i != 5'd0) begin
         rf[wb_rd_i] <= wb_data_i;
      end
   end

   // A stall inserts an all-zero bubble into ID/EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || stall) begin
         id_pc_o        <= 32'h0;
         id_imm_o       <= 32'h0;
         id_rs1_data_o  <= 32'h0;
         id_rs2_data_o  <= 32'h0;
         id_rs1_o       <= 5'd0;
         id_rs2_o       <= 5'd0;
         id_rd_o        <= 5'd0;
         id_alu_op_o    <= 4'h0;
         id_funct3_o    <= 3'd0;
         id_alu_src_o   <= 1'b0;
         id_mem_read_o  <= 1'b0;
         id_mem_write_o <= 1'b0;
         id_reg_write_o <= 1'b0;
         id_illegal_o   <= 1'b0;
      end else begin
         id_pc_o        <= pc_i;
         id_imm_o       <= imm;
         id_rs1_data_o  <= op_a;
         id_rs2_data_o  <= use_rs2 ? rf_rs2 : 32'h0;
         // JALR's rs1 is consumed here; EX must not forward over the zero link operand.
         id_rs1_o       <= (use_rs1 && !is_jalr) ? rs1 : 5'd0;
         id_rs2_o       <= use_rs2 ? rs2 : 5'd0;
         id_rd_o        <= writes_rd ? rd : 5'd0;
         id_alu_op_o    <= is_alu ? {inst_i[30], funct3} : 4'h0;
         id_funct3_o    <= legal ? funct3 : 3'd0;
         id_alu_src_o   <= alu_src;
         id_mem_read_o  <= is_load;
         id_mem_write_o <= is_store;
         id_reg_write_o <= writes_rd && rd != 5'd0;
         id_illegal_o   <= !legal;
      end
   end

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: directed scenarios plus randomized traffic
// checked against a behavioural ID-stage model.
module tb_inst_decode;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, pc_i, wb_data_i, mem_data_i;
   logic        wb_we_i, ex_we_i, ex_mem_read_i, mem_we_i, mem_mem_read_i;
   logic [4:0]  wb_rd_i, ex_rd_i, mem_rd_i;
   logic        pc_stall_o, if_stall_o, if_flush_o, branch_o, jmp_o;
   logic [31:0] pc_branch_o, pc_jmp_o, id_pc_o, id_imm_o, id_rs1_data_o, id_rs2_data_o;
   logic [4:0]  id_rs1_o, id_rs2_o, id_rd_o;
   logic [3:0]  id_alu_op_o;
   logic [2:0]  id_funct3_o;
   logic        id_alu_src_o, id_mem_read_o, id_mem_write_o, id_reg_write_o, id_illegal_o;

   always #5 clk = ~clk;

   inst_decode #(.FLUSH_INST(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .pc_i(pc_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_we_i(ex_we_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
      .mem_we_i(mem_we_i), .mem_mem_read_i(mem_mem_read_i), .mem_rd_i(mem_rd_i),
      .mem_data_i(mem_data_i),
      .pc_stall_o(pc_stall_o), .if_stall_o(if_stall_o), .if_flush_o(if_flush_o),
      .branch_o(branch_o), .pc_branch_o(pc_branch_o), .jmp_o(jmp_o), .pc_jmp_o(pc_jmp_o),
      .id_pc_o(id_pc_o), .id_imm_o(id_imm_o), .id_rs1_data_o(id_rs1_data_o),
      .id_rs2_data_o(id_rs2_data_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o),
      .id_rd_o(id_rd_o), .id_alu_op_o(id_alu_op_o), .id_funct3_o(id_funct3_o),
      .id_alu_src_o(id_alu_src_o), .id_mem_read_o(id_mem_read_o),
      .id_mem_write_o(id_mem_write_o), .id_reg_write_o(id_reg_write_o),
      .id_illegal_o(id_illegal_o)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_rf [32];
   logic [6:0]  op_tab [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   localparam logic [31:0] Nop = 32'h0000_0013;

   function automatic logic [31:0] enc_r(logic [4:0] r2, logic [4:0] r1, logic [4:0] rd);
      return {7'd0, r2, r1, 3'd0, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [4:0] rd,
                                         logic [6:0] op);
      return {imm, r1, 3'd0, rd, op};
   endfunction

   function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [68:0] obs_comb();
      return {pc_stall_o, if_stall_o, if_flush_o, branch_o, branch_o ? pc_branch_o : 32'h0,
              jmp_o, jmp_o ? pc_jmp_o : 32'h0};
   endfunction

   function automatic logic [154:0] obs_idex();
      return {id_pc_o, id_imm_o, id_rs1_data_o, id_rs2_data_o, id_rs1_o, id_rs2_o, id_rd_o,
              id_alu_op_o, id_funct3_o, id_alu_src_o, id_mem_read_o, id_mem_write_o,
              id_reg_write_o, id_illegal_o};
   endfunction

   // Architectural register value as seen in ID (WB writes are visible the same cycle).
   function automatic logic [31:0] reg_val(logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_we_i && wb_rd_i == r) return wb_data_i;
      return ref_rf[r];
   endfunction

   function automatic logic [31:0] br_val(logic [4:0] r);
      if (r != 5'd0 && mem_we_i && !mem_mem_read_i && mem_rd_i == r) return mem_data_i;
      return reg_val(r);
   endfunction

   task automatic model(output logic [68:0] c, output logic [154:0] x);
      logic [6:0]  op;
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic        lui, aui, jal, jalr, br, ld, st, opi, opr, legal, u1, u2, wr, tk, hz;
      logic        m_ex, m_mem, brt, jm;
      logic [31:0] a, b, ii, is, ib, iu, ij, imm, d1, d2, pcb, pcj;
      op = inst_i[6:0];
      rd = inst_i[11:7];
      f3 = inst_i[14:12];
      r1 = inst_i[19:15];
      r2 = inst_i[24:20];
      lui = op == 7'h37; aui = op == 7'h17; jal = op == 7'h6f; jalr = op == 7'h67;
      br = op == 7'h63; ld = op == 7'h03; st = op == 7'h23; opi = op == 7'h13;
      opr = op == 7'h33;
      legal = lui | aui | jal | jalr | br | ld | st | opi | opr;
      u1 = jalr | br | ld | st | opi | opr;
      u2 = br | st | opr;
      wr = lui | aui | jal | jalr | ld | opi | opr;
      ii = 32'($signed(inst_i[31:20]));
      is = 32'($signed({inst_i[31:25], inst_i[11:7]}));
      ib = 32'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      ij = 32'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      iu = 32'(inst_i[31:12]) * 32'd4096;
      a = br_val(r1);
      b = br_val(r2);
      case (f3)
         3'd0: tk = a == b;
         3'd1: tk = a != b;
         3'd4: tk = $signed(a) < $signed(b);
         3'd5: tk = $signed(a) >= $signed(b);
         3'd6: tk = a < b;
         3'd7: tk = a >= b;
         default: tk = 1'b0;
      endcase
      m_ex  = ex_rd_i != 0 && ((u1 && ex_rd_i == r1) || (u2 && ex_rd_i == r2));
      m_mem = mem_rd_i != 0 && ((u1 && mem_rd_i == r1) || (u2 && mem_rd_i == r2));
      hz = (ex_mem_read_i && m_ex) || ((br | jalr) && ((ex_we_i && m_ex) ||
                                                       (mem_mem_read_i && m_mem)));
      brt = !hz && br && tk;
      jm  = !hz && (jal | jalr);
      pcb = pc_i + ib;
      pcj = jal ? pc_i + ij : (a + ii) & 32'hFFFF_FFFE;
      c = {hz, hz, brt | jm, brt, brt ? pcb : 32'h0, jm, jm ? pcj : 32'h0};
      if (lui | aui) imm = iu;
      else if (jal | jalr) imm = pc_i + 32'd4;
      else if (ld | opi) imm = ii;
      else if (st) imm = is;
      else if (br) imm = ib;
      else imm = 32'h0;
      d1 = aui ? pc_i : ((br | ld | st | opi | opr) ? reg_val(r1) : 32'h0);
      d2 = u2 ? reg_val(r2) : 32'h0;
      if (hz) x = '0;
      else x = {pc_i, imm, d1, d2, (br | ld | st | opi | opr) ? r1 : 5'd0, u2 ? r2 : 5'd0,
                wr ? rd : 5'd0, (opi | opr) ? {inst_i[30], f3} : 4'h0, legal ? f3 : 3'd0,
                lui | aui | jal | jalr | ld | st | opi, ld, st, wr && rd != 0, !legal};
   endtask

   task automatic clear_side();
      wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
      ex_we_i = 0; ex_mem_read_i = 0; ex_rd_i = 0;
      mem_we_i = 0; mem_mem_read_i = 0; mem_rd_i = 0; mem_data_i = 0;
   endtask

   task automatic put(input logic [31:0] inst, input logic [31:0] pc);
      @(negedge clk);
      inst_i = inst;
      pc_i = pc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (wb_we_i && wb_rd_i != 5'd0) ref_rf[wb_rd_i] = wb_data_i;
      #1;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
      clear_side();
      wb_we_i = 1; wb_rd_i = r; wb_data_i = v;
      put(Nop, 32'h0);
      tick();
      clear_side();
   endtask

   task automatic test_reset();
      rst = 1;
      clear_side();
      put(enc_r(5'd0, 5'd5, 5'd6), 32'h1234);
      tick();
      checks++;
      if (obs_idex() !== 155'd0) begin
         errors++; $display("FAIL reset_idex got %h want 0", obs_idex());
      end
      checks++;
      if (pc_stall_o !== 1'b0 || if_flush_o !== 1'b0) begin
         errors++; $display("FAIL reset_comb got stall=%b flush=%b want 0 0",
                            pc_stall_o, if_flush_o);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_wb_bypass();
      clear_side();
      wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'hDEAD_BEEF;
      put(enc_r(5'd0, 5'd5, 5'd6), 32'h10);
      tick();
      checks++;
      if (id_rs1_data_o !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL wb_bypass got %h want deadbeef", id_rs1_data_o);
      end
      checks++;
      if (id_rd_o !== 5'd6 || id_reg_write_o !== 1'b1) begin
         errors++; $display("FAIL wb_bypass_rd got rd=%0d rw=%b want 6 1",
                            id_rd_o, id_reg_write_o);
      end
      clear_side();
      put(enc_r(5'd0, 5'd5, 5'd6), 32'h14);
      tick();
      checks++;
      if (id_rs1_data_o !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rf_written got %h want deadbeef", id_rs1_data_o);
      end
   endtask

   task automatic test_load_use();
      clear_side();
      ex_we_i = 1; ex_mem_read_i = 1; ex_rd_i = 1;
      put(enc_r(5'd3, 5'd1, 5'd2), 32'h40);
      checks++;
      if (pc_stall_o !== 1'b1 || if_stall_o !== 1'b1 || if_flush_o !== 1'b0) begin
         errors++; $display("FAIL load_use_stall got %b%b%b want 110",
                            pc_stall_o, if_stall_o, if_flush_o);
      end
      tick();
      checks++;
      if (obs_idex() !== 155'd0) begin
         errors++; $display("FAIL load_use_bubble got %h want 0", obs_idex());
      end
      clear_side();
      put(enc_r(5'd3, 5'd1, 5'd2), 32'h40);
      checks++;
      if (pc_stall_o !== 1'b0) begin
         errors++; $display("FAIL load_use_release got %b want 0", pc_stall_o);
      end
      tick();
      checks++;
      if (id_rs1_o !== 5'd1 || id_rd_o !== 5'd2 || id_reg_write_o !== 1'b1) begin
         errors++; $display("FAIL load_use_issue got rs1=%0d rd=%0d rw=%b want 1 2 1",
                            id_rs1_o, id_rd_o, id_reg_write_o);
      end
      checks++;
      if (id_pc_o !== 32'h40) begin
         errors++; $display("FAIL load_use_pc got %h want 40", id_pc_o);
      end
   endtask

   task automatic test_branch();
      wb_write(5'd1, 32'd7);
      wb_write(5'd2, 32'd7);
      put(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h100);
      checks++;
      if (branch_o !== 1'b1 || pc_branch_o !== 32'h110) begin
         errors++; $display("FAIL beq_taken got br=%b tgt=%h want 1 110", branch_o, pc_branch_o);
      end
      checks++;
      if (if_flush_o !== 1'b1 || jmp_o !== 1'b0) begin
         errors++; $display("FAIL beq_flush got flush=%b jmp=%b want 1 0", if_flush_o, jmp_o);
      end
      tick();
      put(enc_b(13'd16, 5'd2, 5'd1, 3'd1), 32'h104);
      checks++;
      if (branch_o !== 1'b0 || if_flush_o !== 1'b0) begin
         errors++; $display("FAIL bne_not_taken got br=%b flush=%b want 0 0",
                            branch_o, if_flush_o);
      end
      tick();
   endtask

   task automatic test_jalr();
      wb_write(5'd4, 32'h2005);
      put(enc_i(12'hFFD, 5'd4, 5'd1, 7'h67), 32'h300);
      checks++;
      if (jmp_o !== 1'b1 || pc_jmp_o !== 32'h2002) begin
         errors++; $display("FAIL jalr_target got jmp=%b tgt=%h want 1 2002", jmp_o, pc_jmp_o);
      end
      checks++;
      if (if_flush_o !== 1'b1 || branch_o !== 1'b0) begin
         errors++; $display("FAIL jalr_flush got flush=%b br=%b want 1 0", if_flush_o, branch_o);
      end
      tick();
      checks++;
      if (id_rd_o !== 5'd1 || id_imm_o !== 32'h304) begin
         errors++; $display("FAIL jalr_link got rd=%0d imm=%h want 1 304", id_rd_o, id_imm_o);
      end
      checks++;
      if (id_reg_write_o !== 1'b1 || id_alu_src_o !== 1'b1 || id_rs1_data_o !== 32'h0) begin
         errors++; $display("FAIL jalr_ctl got rw=%b src=%b rs1d=%h want 1 1 0",
                            id_reg_write_o, id_alu_src_o, id_rs1_data_o);
      end
   endtask

   task automatic test_mem_forward();
      clear_side();
      mem_we_i = 1; mem_rd_i = 4; mem_data_i = 32'h40;
      put(enc_b(13'd8, 5'd0, 5'd4, 3'd0), 32'h200);
      checks++;
      if (branch_o !== 1'b0 || pc_stall_o !== 1'b0) begin
         errors++; $display("FAIL memfwd_40 got br=%b stall=%b want 0 0", branch_o, pc_stall_o);
      end
      mem_data_i = 32'h0;
      #1;
      checks++;
      if (branch_o !== 1'b1 || pc_branch_o !== 32'h208) begin
         errors++; $display("FAIL memfwd_0 got br=%b tgt=%h want 1 208", branch_o, pc_branch_o);
      end
      mem_mem_read_i = 1;
      #1;
      checks++;
      if (pc_stall_o !== 1'b1 || branch_o !== 1'b0 || if_flush_o !== 1'b0) begin
         errors++; $display("FAIL memload_stall got stall=%b br=%b flush=%b want 1 0 0",
                            pc_stall_o, branch_o, if_flush_o);
      end
      clear_side();
      ex_we_i = 1; ex_rd_i = 4;
      #1;
      checks++;
      if (pc_stall_o !== 1'b1) begin
         errors++; $display("FAIL ex_branch_stall got %b want 1", pc_stall_o);
      end
      tick();
      clear_side();
   endtask

   task automatic test_random();
      logic [68:0]  ec;
      logic [154:0] ex;
      logic [31:0]  ins;
      int           k;
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 9);
         ins = $urandom;
         ins[6:0] = (k == 9) ? 7'($urandom) : op_tab[k];
         ins[11:7] = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 7));
         wb_we_i = 1'($urandom_range(0, 1));
         wb_rd_i = 5'($urandom_range(0, 7));
         wb_data_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_we_i = 1'($urandom_range(0, 1));
         ex_mem_read_i = $urandom_range(0, 3) == 0;
         ex_rd_i = 5'($urandom_range(0, 7));
         mem_we_i = 1'($urandom_range(0, 1));
         mem_mem_read_i = $urandom_range(0, 3) == 0;
         mem_rd_i = 5'($urandom_range(0, 7));
         mem_data_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         put(ins, $urandom);
         model(ec, ex);
         checks++;
         if (obs_comb() !== ec) begin
            errors++; $display("FAIL rand_comb n=%0d inst=%h got %h want %h",
                               n, ins, obs_comb(), ec);
         end
         tick();
         checks++;
         if (obs_idex() !== ex) begin
            errors++; $display("FAIL rand_idex n=%0d inst=%h got %h want %h",
                               n, ins, obs_idex(), ex);
         end
      end
      clear_side();
   endtask

   task automatic test_illegal_and_reset();
      clear_side();
      put(32'hFFFF_FFFF, 32'h500);
      checks++;
      if (jmp_o !== 1'b0 || branch_o !== 1'b0 || if_flush_o !== 1'b0) begin
         errors++; $display("FAIL illegal_redirect got %b%b%b want 000",
                            jmp_o, branch_o, if_flush_o);
      end
      tick();
      checks++;
      if (id_illegal_o !== 1'b1 || {id_alu_src_o, id_mem_read_o, id_mem_write_o,
                                     id_reg_write_o} !== 4'b0 || id_rd_o !== 5'd0) begin
         errors++; $display("FAIL illegal_ctl got ill=%b ctl=%b rd=%0d want 1 0000 0",
                            id_illegal_o, {id_alu_src_o, id_mem_read_o, id_mem_write_o,
                                           id_reg_write_o}, id_rd_o);
      end
      wb_write(5'd9, 32'h1234_5678);
      put(enc_r(5'd2, 5'd9, 5'd7), 32'h504);
      tick();
      checks++;
      if (id_reg_write_o !== 1'b1 || id_rs1_data_o !== 32'h1234_5678) begin
         errors++; $display("FAIL pre_reset got rw=%b rs1d=%h want 1 12345678",
                            id_reg_write_o, id_rs1_data_o);
      end
      #2 rst = 1;
      #1;
      checks++;
      if (obs_idex() !== 155'd0) begin
         errors++; $display("FAIL async_reset got %h want 0", obs_idex());
      end
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      @(negedge clk);
      rst = 0;
      for (int r = 1; r < 32; r++) begin
         put(enc_r(5'(r), 5'(r), 5'd0), 32'h600);
         tick();
         checks++;
         if (id_rs1_data_o !== 32'h0 || id_rs2_data_o !== 32'h0) begin
            errors++; $display("FAIL rf_cleared x%0d got %h/%h want 0",
                               r, id_rs1_data_o, id_rs2_data_o);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      inst_i = Nop;
      pc_i = 32'h0;
      test_reset();
      test_wb_bypass();
      test_load_use();
      test_branch();
      test_jalr();
      test_mem_forward();
      test_random();
      test_illegal_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
